// File: rtl/adc_peak_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : adc_peak_capture                                              |
// | Brief    : 2-stage signed peak finder on multi-sample ADC words, plus a  |
// |            triggered capture engine buffering words into a FWFT FIFO     |
// |            drained over AXI-Stream. Define ADC_CAPTURE_TLAST_EN to add   |
// |            m_axis_tlast on the final word of each capture.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module adc_peak_capture #(
    parameter int SAMPLES  = 8,
    parameter int SAMPLE_W = 16,
    parameter int DEPTH    = 1024,
    parameter int LEN_W    = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SAMPLES*SAMPLE_W-1:0]   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [SAMPLE_W-1:0]           peak_val,
    output logic [$clog2(SAMPLES)-1:0]    peak_pos,
    output logic                          peak_valid,
    input  logic                          cfg_trig,
    input  logic                          cfg_mode,
    input  logic [SAMPLE_W-1:0]           cfg_thresh,
    input  logic [LEN_W-1:0]              cfg_len,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic [SAMPLES*SAMPLE_W-1:0]   m_axis_tdata,
    output logic                          m_axis_tvalid,
`ifdef ADC_CAPTURE_TLAST_EN
    output logic                          m_axis_tlast,
`endif
    input  logic                          m_axis_tready
);

    localparam int                c_W         = SAMPLES * SAMPLE_W;
    localparam int                c_POS_W     = $clog2(SAMPLES);
    localparam int                c_AW        = $clog2(DEPTH);
    localparam logic [LEN_W-1:0]  c_DEPTH_LEN = LEN_W'(DEPTH);
    localparam logic [c_AW:0]     c_DEPTH_CNT = (c_AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // ---------------- peak pipeline ----------------
    logic [SAMPLES-1:0][SAMPLE_W-1:0] w_mag;
    logic [SAMPLES-1:0][SAMPLE_W-1:0] r_s1_mag;
    logic [c_W-1:0]                   r_s1_data;
    logic                             r_s1_valid;
    logic [c_W-1:0]                   r_s2_data;
    logic                             r_s2_valid;
    logic [SAMPLE_W-1:0]              r_peak_val;
    logic [SAMPLE_W-1:0]              r_peak_mag;
    logic [c_POS_W-1:0]               r_peak_pos;
    logic [SAMPLE_W-1:0]              w_best_mag;
    logic [SAMPLE_W-1:0]              w_best_val;
    logic [c_POS_W-1:0]               w_best_pos;

    // Two's-complement negate wraps -2^(W-1) onto itself, which read unsigned is the true magnitude.
    generate
        for (genvar i = 0; i < SAMPLES; i++) begin : g_mag
            logic [SAMPLE_W-1:0] w_smp;
            assign w_smp    = s_axis_tdata[i*SAMPLE_W +: SAMPLE_W];
            assign w_mag[i] = w_smp[SAMPLE_W-1] ? (~w_smp + SAMPLE_W'(1)) : w_smp;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_mag   <= '0;
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_mag   <= w_mag;
            r_s1_data  <= s_axis_tdata;
            r_s1_valid <= s_axis_tvalid;
        end
    end

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        w_best_mag = r_s1_mag[0];
        w_best_val = r_s1_data[SAMPLE_W-1:0];
        w_best_pos = '0;
        for (int i = 1; i < SAMPLES; i++) begin
            if (r_s1_mag[i] > w_best_mag) begin
                w_best_mag = r_s1_mag[i];
                w_best_val = r_s1_data[i*SAMPLE_W +: SAMPLE_W];
                w_best_pos = c_POS_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_data  <= '0;
            r_s2_valid <= 1'b0;
            r_peak_val <= '0;
            r_peak_mag <= '0;
            r_peak_pos <= '0;
        end else begin
            r_s2_data  <= r_s1_data;
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_peak_val <= w_best_val;
                r_peak_mag <= w_best_mag;
                r_peak_pos <= w_best_pos;
            end
        end
    end

    assign s_axis_tready = 1'b1;
    assign peak_val      = r_peak_val;
    assign peak_pos      = r_peak_pos;
    assign peak_valid    = r_s2_valid;

    // ---------------- capture FSM ----------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_trig_d;
    logic [LEN_W-1:0]   r_remain;
    logic [LEN_W-1:0]   w_len;
    logic               w_trig_rise;
    logic               w_thresh_hit;
    logic               w_start;
    logic               w_wr;

    // Not reset: a trigger held high across reset must not look like a fresh edge.
    always_ff @(posedge clk) begin
        r_trig_d <= cfg_trig;
    end

    assign w_trig_rise  = cfg_trig & ~r_trig_d;
    assign w_thresh_hit = r_s2_valid && (r_peak_mag >= cfg_thresh);

    always_comb begin
        if (cfg_len == '0) begin
            w_len = LEN_W'(1);
        end else if (cfg_len > c_DEPTH_LEN) begin
            w_len = c_DEPTH_LEN;
        end else begin
            w_len = cfg_len;
        end
    end

    // The mode chosen at the edge is held implicitly by the ARMED/CAPTURE state.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_wr        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trig_rise) begin
                    w_start     = 1'b1;
                    w_state_nxt = cfg_mode ? ST_ARMED : ST_CAPTURE;
                end
            end
            ST_ARMED: begin
                if (!cfg_trig) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_thresh_hit) begin
                    w_wr        = 1'b1;
                    w_state_nxt = (r_remain == LEN_W'(1)) ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (r_s2_valid) begin
                    w_wr = 1'b1;
                    if (r_remain == LEN_W'(1)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!cfg_trig) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_remain <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_remain <= w_len;
            end else if (w_wr) begin
                r_remain <= r_remain - LEN_W'(1);
            end
        end
    end

    assign busy = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
    assign done = (r_state == ST_DONE);

    // ---------------- capture FIFO ----------------
    logic [c_W-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             r_overflow;
    logic             w_full;
    logic             w_rd;
    logic             w_push;
    logic             w_drop;

    assign m_axis_tvalid = (r_count != '0);
    assign w_full        = (r_count == c_DEPTH_CNT);
    assign w_rd          = m_axis_tvalid & m_axis_tready;
    // A same-cycle read frees the slot, so a full FIFO still accepts the write.
    assign w_push        = w_wr & (~w_full | w_rd);
    assign w_drop        = w_wr & ~w_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_start) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_s2_data;
        end
    end

    assign m_axis_tdata = m_axis_tvalid ? r_mem[r_rd_ptr] : '0;
    assign overflow     = r_overflow;

`ifdef ADC_CAPTURE_TLAST_EN
    logic             r_last_mem [DEPTH];
    logic             r_stored_any;
    logic             w_final;
    logic [c_AW-1:0]  w_prev_ptr;

    assign w_final    = (r_remain == LEN_W'(1));
    assign w_prev_ptr = r_wr_ptr - 1'b1;

    // A dropped final word moves tlast back onto this capture's newest stored entry,
    // which is necessarily still queued because the FIFO is full.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_last_mem[r_wr_ptr] <= w_final;
        end else if (w_drop && w_final && r_stored_any) begin
            r_last_mem[w_prev_ptr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stored_any <= 1'b0;
        end else if (w_start) begin
            r_stored_any <= 1'b0;
        end else if (w_push) begin
            r_stored_any <= 1'b1;
        end
    end

    assign m_axis_tlast = m_axis_tvalid & r_last_mem[r_rd_ptr];
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_peak_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_adc_peak_capture                                           |
// | Brief    : Self-checking bench for adc_peak_capture (DEPTH = 16).        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_adc_peak_capture;

    localparam int SAMPLES  = 8;
    localparam int SAMPLE_W = 16;
    localparam int DEPTH    = 16;
    localparam int LEN_W    = 5;
    localparam int W        = SAMPLES * SAMPLE_W;
    localparam int PW       = $clog2(SAMPLES);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [W-1:0]         s_axis_tdata;
    logic                 s_axis_tvalid;
    logic                 s_axis_tready;
    logic [SAMPLE_W-1:0]  peak_val;
    logic [PW-1:0]        peak_pos;
    logic                 peak_valid;
    logic                 cfg_trig;
    logic                 cfg_mode;
    logic [SAMPLE_W-1:0]  cfg_thresh;
    logic [LEN_W-1:0]     cfg_len;
    logic                 busy;
    logic                 done;
    logic                 overflow;
    logic [W-1:0]         m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 tlast_s;

    adc_peak_capture #(
        .SAMPLES  (SAMPLES),
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (DEPTH),
        .LEN_W    (LEN_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .peak_val      (peak_val),
        .peak_pos      (peak_pos),
        .peak_valid    (peak_valid),
        .cfg_trig      (cfg_trig),
        .cfg_mode      (cfg_mode),
        .cfg_thresh    (cfg_thresh),
        .cfg_len       (cfg_len),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
`ifdef ADC_CAPTURE_TLAST_EN
        .m_axis_tlast  (tlast_s),
`endif
        .m_axis_tready (m_axis_tready)
    );

`ifndef ADC_CAPTURE_TLAST_EN
    assign tlast_s = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]        word;
        logic [SAMPLE_W-1:0] val;
        logic [PW-1:0]       pos;
    } peak_vec_t;

    typedef struct {
        logic [SAMPLE_W-1:0] val;
        logic [PW-1:0]       pos;
    } peak_exp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    peak_exp_t   peak_q[$];
    logic [W-1:0] obs_q[$];
    logic        obs_last_q[$];
    peak_vec_t   vecs[6];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        int           s[SAMPLES];
        logic [W-1:0] r;
        s = '{a0, a1, a2, a3, a4, a5, a6, a7};
        r = '0;
        for (int i = 0; i < SAMPLES; i++) r[i*SAMPLE_W +: SAMPLE_W] = s[i][SAMPLE_W-1:0];
        return r;
    endfunction

    // Reference peak: largest |sample| computed in int arithmetic, first index wins ties.
    function automatic peak_exp_t model(input logic [W-1:0] w);
        peak_exp_t r;
        int        best;
        int        v;
        int        m;
        best  = -1;
        r.val = '0;
        r.pos = '0;
        for (int i = 0; i < SAMPLES; i++) begin
            v = $signed(w[i*SAMPLE_W +: SAMPLE_W]);
            m = (v < 0) ? -v : v;
            if (m > best) begin
                best  = m;
                r.val = w[i*SAMPLE_W +: SAMPLE_W];
                r.pos = PW'(i);
            end
        end
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [W-1:0] w);
        s_axis_tdata  = w;
        s_axis_tvalid = 1'b1;
        peak_q.push_back(model(w));
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Scoreboard: pop the expected peak whenever the DUT reports one; log every drained word.
    always @(negedge clk) begin
        if (mon_en) begin
            if (peak_valid) begin
                if (peak_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL peak_extra: got peak_valid=1 required no pending beat");
                end else begin
                    peak_exp_t e;
                    e = peak_q.pop_front();
                    check("peak_val", W'(peak_val), W'(e.val));
                    check("peak_pos", W'(peak_pos), W'(e.pos));
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                obs_q.push_back(m_axis_tdata);
                obs_last_q.push_back(tlast_s);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w1000;
        logic [W-1:0] w1200;

        vecs[0] = '{mk(0, 0, 0, 500, 0, -32768, -500, 0), 16'h8000, 3'd5};
        vecs[1] = '{mk(0, 0, 0, 500, 0, 0, -500, 0),      16'h01F4, 3'd3};
        vecs[2] = '{mk(0, 0, 0, 0, 0, 0, 0, 0),           16'h0000, 3'd0};
        vecs[3] = '{mk(7, -7, 7, 0, 0, 0, 0, 0),          16'h0007, 3'd0};
        vecs[4] = '{mk(0, 0, 0, 0, 0, 0, 0, -1),          16'hFFFF, 3'd7};
        vecs[5] = '{mk(0, 0, 32767, 0, -32768, 0, 0, 0),  16'h8000, 3'd4};

        rst = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
        cfg_trig = 1'b0; cfg_mode = 1'b0; cfg_thresh = '0; cfg_len = '0; m_axis_tready = 1'b1;
        cyc(); cyc(); cyc();
        rst = 1'b0;
        check("rst_peak_valid", W'(peak_valid), '0);
        check("rst_peak_val",   W'(peak_val), '0);
        check("rst_peak_pos",   W'(peak_pos), '0);
        check("rst_busy",       W'(busy), '0);
        check("rst_done",       W'(done), '0);
        check("rst_overflow",   W'(overflow), '0);
        check("rst_m_tvalid",   W'(m_axis_tvalid), '0);
        check("rst_s_tready",   W'(s_axis_tready), W'(1));
        mon_en = 1'b1;

        // Single beat: 2-cycle latency, then values hold while peak_valid drops.
        beat(mk(100, -300, 200, 0, 0, 0, 0, 0));
        cyc();
        s_axis_tvalid = 1'b0;
        cyc();
        check("lat_valid", W'(peak_valid), W'(1));
        check("lat_val",   W'(peak_val), W'(16'hFED4));
        check("lat_pos",   W'(peak_pos), W'(1));
        cyc();
        check("hold_valid", W'(peak_valid), '0);
        check("hold_val",   W'(peak_val), W'(16'hFED4));
        check("hold_pos",   W'(peak_pos), W'(1));

        // Table vectors back-to-back, then a few random words.
        for (int i = 0; i < 6; i++) begin
            s_axis_tdata  = vecs[i].word;
            s_axis_tvalid = 1'b1;
            peak_q.push_back('{vecs[i].val, vecs[i].pos});
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            beat({$urandom, $urandom, $urandom, $urandom});
            cyc();
        end
        idle(4);
        check("peak_drained", W'(peak_q.size()), '0);

        // Manual capture, len 4, continuous counter beats.
        obs_q.delete(); obs_last_q.delete();
        cfg_mode = 1'b0; cfg_len = 5'd4;
        for (int k = 0; k < 12; k++) begin
            beat(W'(1000 + k));
            if (k == 2) cfg_trig = 1'b1;
            cyc();
        end
        idle(4);
        check("man_done", W'(done), W'(1));
        check("man_busy", W'(busy), '0);
        check("man_count", W'(obs_q.size()), W'(4));
        if (obs_q.size() == 4) begin
            check("man_base", W'(obs_q[0] >= W'(1000) && obs_q[0] <= W'(1011)), W'(1));
            for (int i = 1; i < 4; i++) check("man_consec", obs_q[i], obs_q[0] + W'(i));
`ifdef ADC_CAPTURE_TLAST_EN
            check("man_tlast3", W'(obs_last_q[3]), W'(1));
            check("man_tlast0", W'(obs_last_q[0]), '0);
`endif
        end
        cfg_trig = 1'b0;
        cyc(); cyc();
        check("man_done_clr", W'(done), '0);

        // Threshold capture: only the >= 1000 beats are captured.
        obs_q.delete(); obs_last_q.delete();
        cfg_mode = 1'b1; cfg_thresh = 16'd1000; cfg_len = 5'd2; cfg_trig = 1'b1;
        idle(3);
        check("thr_armed_busy", W'(busy), W'(1));
        w1000 = mk(1000, 0, 0, 0, 0, 0, 0, 0);
        w1200 = mk(0, 0, 0, 0, 0, 0, 0, -1200);
        beat(mk(0, 500, 0, 0, 0, 0, 0, 0));   cyc();
        beat(mk(0, 0, 0, 0, -999, 0, 0, 0));  cyc();
        beat(w1000);                          cyc();
        beat(w1200);                          cyc();
        beat(mk(0, 0, 0, 50, 0, 0, 0, 0));    cyc();
        idle(5);
        check("thr_count", W'(obs_q.size()), W'(2));
        if (obs_q.size() == 2) begin
            check("thr_word0", obs_q[0], w1000);
            check("thr_word1", obs_q[1], w1200);
        end
        check("thr_done", W'(done), W'(1));
        cfg_trig = 1'b0;
        cyc();

        // Trigger falling while armed returns to IDLE; later hits capture nothing.
        obs_q.delete(); obs_last_q.delete();
        cfg_trig = 1'b1; idle(2);
        cfg_trig = 1'b0; idle(2);
        check("arm_abort_busy", W'(busy), '0);
        beat(w1200); cyc();
        idle(4);
        check("arm_abort_none", W'(obs_q.size()), '0);
        check("arm_abort_done", W'(done), '0);

        // Overflow: 4 leftover words, then len 20 (clamped to 16) with no draining.
        obs_q.delete(); obs_last_q.delete();
        m_axis_tready = 1'b0; cfg_mode = 1'b0; cfg_len = 5'd4; cfg_trig = 1'b1;
        for (int k = 0; k < 10; k++) begin beat(W'(2000 + k)); cyc(); end
        cfg_trig = 1'b0;
        idle(2);
        check("ovf_pre_tvalid", W'(m_axis_tvalid), W'(1));
        check("ovf_pre_flag", W'(overflow), '0);
        cfg_len = 5'd20; cfg_trig = 1'b1;
        for (int k = 0; k < 24; k++) begin beat(W'(3000 + k)); cyc(); end
        idle(2);
        check("ovf_flag", W'(overflow), W'(1));
        check("ovf_done", W'(done), W'(1));
        check("ovf_busy", W'(busy), '0);
        cfg_trig = 1'b0;
        idle(2);
        check("ovf_sticky", W'(overflow), W'(1));
        m_axis_tready = 1'b1;
        idle(20);
        check("ovf_drain_count", W'(obs_q.size()), W'(16));
        if (obs_q.size() == 16) begin
            check("ovf_old_base", W'(obs_q[0] >= W'(2000) && obs_q[0] <= W'(2009)), W'(1));
            check("ovf_new_base", W'(obs_q[4] >= W'(3000) && obs_q[4] <= W'(3023)), W'(1));
            for (int i = 1; i < 4; i++)  check("ovf_old_consec", obs_q[i], obs_q[0] + W'(i));
            for (int i = 5; i < 16; i++) check("ovf_new_consec", obs_q[i], obs_q[4] + W'(i - 4));
`ifdef ADC_CAPTURE_TLAST_EN
            check("ovf_tlast_old", W'(obs_last_q[3]), W'(1));
            check("ovf_tlast_new", W'(obs_last_q[15]), W'(1));
            check("ovf_tlast_mid", W'(obs_last_q[10]), '0);
`endif
        end
        check("ovf_empty", W'(m_axis_tvalid), '0);
        check("ovf_held", W'(overflow), W'(1));
        cfg_mode = 1'b1; cfg_trig = 1'b1;
        idle(2);
        check("ovf_clr_on_edge", W'(overflow), '0);
        check("ovf_rearm_busy", W'(busy), W'(1));
        cfg_trig = 1'b0;
        idle(2);
        check("ovf_rearm_abort", W'(busy), '0);
        check("pre_rst_peak_q", W'(peak_q.size()), '0);

        // Reset on the 3rd capture cycle discards the partial capture.
        mon_en = 1'b0;
        m_axis_tready = 1'b0; cfg_mode = 1'b0; cfg_len = 5'd8;
        beat(W'(4000)); cfg_trig = 1'b1;
        cyc();
        beat(W'(4001)); cyc();
        beat(W'(4002)); cyc();
        rst = 1'b1;
        beat(W'(4003)); cyc();
        check("mid_rst_valid",    W'(peak_valid), '0);
        check("mid_rst_val",      W'(peak_val), '0);
        check("mid_rst_pos",      W'(peak_pos), '0);
        check("mid_rst_busy",     W'(busy), '0);
        check("mid_rst_done",     W'(done), '0);
        check("mid_rst_overflow", W'(overflow), '0);
        check("mid_rst_tvalid",   W'(m_axis_tvalid), '0);
        check("mid_rst_tdata",    m_axis_tdata, '0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin beat(W'(5000 + k)); cyc(); end
        check("post_rst_busy",   W'(busy), '0);
        check("post_rst_tvalid", W'(m_axis_tvalid), '0);
        check("post_rst_done",   W'(done), '0);
        cfg_trig = 1'b0;
        idle(3);
        peak_q.delete();
        m_axis_tready = 1'b1;
        mon_en = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
